// File: rtl/apb_irq_gen_counter.sv
// ---------------------------------------------------------------------------
// apb_irq_gen_counter
//
// APB3 interrupt stimulus source with NUM_CH independent channels. Software
// fires a channel, the channel raises a level irq (optionally repeated with a
// programmable low gap), waits for the matching ack, and records the number of
// acknowledged interrupts plus the latency of the most recent ack.
//
// Optional build macro: ACK_TIMEOUT_EN -- when defined, a channel left in
// ASSERT for TIMEOUT cycles without an ack gives up on that repeat and sets
// a sticky timeout flag (STATUS bit16). When undefined, irq is held until ack.
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE    APB3 control
//   PADDR[15:0]            byte address
//   PWDATA[31:0]           write data
//   PRDATA[31:0]           read data (combinational in read access phase)
//   PREADY                 always 1
//   PSLVERR                access-phase error
//   irq[NUM_CH-1:0]        registered level interrupt per channel
//   ack[NUM_CH-1:0]        acknowledge per channel, synchronous to PCLK
// ---------------------------------------------------------------------------
module apb_irq_gen_counter #(
  parameter int          NUM_CH  = 3,
  parameter int          CNT_W   = 16,
  parameter logic [31:0] VERSION = 32'h0002_0000,
  parameter int          TIMEOUT = 1024
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [15:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] irq,
  input  logic [NUM_CH-1:0] ack
);

  localparam logic [1:0]       ST_IDLE   = 2'd0;
  localparam logic [1:0]       ST_ASSERT = 2'd1;
  localparam logic [1:0]       ST_GAP    = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Address decode
  logic       access, is_ver, is_glb, is_chan, ch_hit;
  logic [3:0] ch_idx;
  logic [1:0] ch_off;

  assign access  = PSEL & PENABLE;
  assign is_ver  = (PADDR == 16'h0000);
  assign is_glb  = (PADDR == 16'h0004);
  assign ch_idx  = PADDR[7:4];
  assign ch_off  = PADDR[3:2];
  assign is_chan = (PADDR[15:8] == 8'h01) && (PADDR[1:0] == 2'b00);
  assign ch_hit  = is_chan && (int'(ch_idx) < NUM_CH);

  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] fire_err;
  logic [31:0]       ch_rdata [NUM_CH];

  logic global_en_reg;
  logic unmapped, ro_wr, slverr, wr_ok, glb_wr, clr, force_idle;

  assign unmapped   = ~(is_ver | is_glb | ch_hit);
  assign ro_wr      = PWRITE & (is_ver | (ch_hit & (ch_off != 2'd0)));
  assign slverr     = access & (unmapped | ro_wr | (|fire_err));
  // Any erroring write (including FIRE on a busy channel) is dropped entirely.
  assign wr_ok      = access & PWRITE & ~slverr;
  assign glb_wr     = wr_ok & is_glb;
  assign clr        = glb_wr & PWDATA[1];
  assign force_idle = glb_wr & ~PWDATA[0];

  assign PREADY  = 1'b1;
  assign PSLVERR = slverr;

  // Bits of PWDATA no register looks at.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, PWDATA[7:2]};

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)    global_en_reg <= 1'b0;
    else if (glb_wr) global_en_reg <= PWDATA[0];
  end

  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      if (is_ver)      PRDATA = VERSION;
      else if (is_glb) PRDATA = {31'd0, global_en_reg};
      else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_sel[i]) PRDATA = ch_rdata[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]       state_reg, state_next;
    logic [7:0]       rem_reg, rem_next;
    logic [15:0]      gap_cnt_reg, gap_cnt_next;
    logic [CNT_W-1:0] lat_cnt_reg, lat_cnt_next;
    logic [CNT_W-1:0] count_reg, lat_reg;
    logic [7:0]       rep_reg;
    logic [15:0]      gap_reg;
    logic             irq_reg, irq_next, to_flag_reg;
    logic             ack_evt, to_evt, ctrl_wr, fire, to_hit;
    logic [31:0]      rdata_c;

    assign ch_sel[gi]   = ch_hit && (ch_idx == 4'(gi));
    assign fire_err[gi] = access & PWRITE & ch_sel[gi] & (ch_off == 2'd0)
                        & PWDATA[0] & (state_reg != ST_IDLE);
    assign ctrl_wr      = wr_ok & ch_sel[gi] & (ch_off == 2'd0);
    // FIRE while EN=0 still updates REPEAT/GAP but starts nothing.
    assign fire         = ctrl_wr & PWDATA[0] & global_en_reg;

`ifdef ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;

    // Counts ASSERT cycles like lat_cnt, but is sized to TIMEOUT and never
    // saturates early, so the timeout point is independent of CNT_W.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
        to_cnt_reg <= '0;
      else if (state_next == ST_ASSERT && state_reg != ST_ASSERT)
        to_cnt_reg <= TO_W'(1);
      else if (state_reg == ST_ASSERT && to_cnt_reg != TO_W'(TIMEOUT))
        to_cnt_reg <= to_cnt_reg + 1'b1;
    end
    assign to_hit = (state_reg == ST_ASSERT) && (to_cnt_reg == TO_W'(TIMEOUT));
`else
    assign to_hit = 1'b0;
`endif

    // Next-state logic
    always_comb begin
      state_next   = state_reg;
      rem_next     = rem_reg;
      gap_cnt_next = gap_cnt_reg;
      lat_cnt_next = lat_cnt_reg;
      ack_evt      = 1'b0;
      to_evt       = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fire) begin
            rem_next     = (PWDATA[15:8] == 8'd0) ? 8'd1 : PWDATA[15:8];
            lat_cnt_next = CNT_W'(1);
            state_next   = ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          ack_evt = ack[gi];
          to_evt  = ~ack[gi] & to_hit;     // a same-cycle ack beats the timeout
          if (ack_evt || to_evt) begin
            rem_next = rem_reg - 8'd1;
            if (rem_reg == 8'd1) begin
              state_next = ST_IDLE;
            end else begin
              state_next   = ST_GAP;
              gap_cnt_next = (gap_reg == 16'd0) ? 16'd1 : gap_reg;
            end
          end else if (lat_cnt_reg != CNT_MAX) begin
            lat_cnt_next = lat_cnt_reg + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg <= 16'd1) begin
            state_next   = ST_ASSERT;
            lat_cnt_next = CNT_W'(1);
          end else begin
            gap_cnt_next = gap_cnt_reg - 16'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
      if (force_idle) begin
        state_next = ST_IDLE;
        rem_next   = 8'd0;
      end
    end

    // Output logic: irq tracks the state being entered, so the flop shows
    // the new level in the cycle after the transition edge.
    always_comb begin
      irq_next = (state_next == ST_ASSERT);
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        state_reg   <= ST_IDLE;
        rem_reg     <= '0;
        gap_cnt_reg <= '0;
        lat_cnt_reg <= '0;
        irq_reg     <= 1'b0;
      end else begin
        state_reg   <= state_next;
        rem_reg     <= rem_next;
        gap_cnt_reg <= gap_cnt_next;
        lat_cnt_reg <= lat_cnt_next;
        irq_reg     <= irq_next;
      end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        rep_reg <= '0;
        gap_reg <= '0;
      end else if (ctrl_wr) begin
        rep_reg <= PWDATA[15:8];
        gap_reg <= PWDATA[31:16];
      end
    end

    // Statistics; CLR takes priority over a same-cycle ack.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        count_reg   <= '0;
        lat_reg     <= '0;
        to_flag_reg <= 1'b0;
      end else if (clr) begin
        count_reg   <= '0;
        lat_reg     <= '0;
        to_flag_reg <= 1'b0;
      end else begin
        if (ack_evt) begin
          if (count_reg != CNT_MAX) count_reg <= count_reg + 1'b1;
          lat_reg <= lat_cnt_reg;
        end
        if (to_evt) to_flag_reg <= 1'b1;
      end
    end

    always_comb begin
      case (ch_off)
        2'd0:    rdata_c = {gap_reg, rep_reg, 8'h00};
        2'd1:    rdata_c = 32'(count_reg);
        2'd2:    rdata_c = 32'(lat_reg);
        default: rdata_c = {15'd0, to_flag_reg, rem_reg, 6'd0, state_reg};
      endcase
    end

    assign ch_rdata[gi] = rdata_c;
    assign irq[gi]      = irq_reg;
  end

endmodule

// File: doc/apb_irq_gen_counter.md
Name: apb_irq_gen_counter

Overview:
- Parametrised APB3 interrupt generator/counter; successor to the fixed three-source APB_INT_Count block.
- Provides NUM_CH independent channels. Each channel raises a level IRQ on software command, optionally repeats it with a programmable gap, waits for the matching ack, and counts acknowledged interrupts and ack latency.
- Sits on the peripheral APB bus as an interrupt stimulus/validation source for the platform interrupt controller.

Parameters:
- NUM_CH, 3, number of IRQ channels (1..16).
- CNT_W, 16, width of per-channel count and latency counters (4..32). Both saturate.
- VERSION, 32'h0002_0000, value returned by the VERSION register.
- TIMEOUT, 1024, ack timeout in cycles. Used only with ACK_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  16  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  error, valid in the access phase.
- irq  out  NUM_CH  level interrupt per channel.
- ack  in  NUM_CH  acknowledge per channel, synchronous to PCLK.

Behaviour:
- Reset (async, PRESETn=0): all irq=0, all counters=0, all FSMs IDLE, GLOBAL=0, PRDATA=0, PSLVERR=0.
- APB access phase = PSEL&PENABLE. Writes commit on the PCLK edge ending the access phase.
- PRDATA is combinational during read access phases and 0 otherwise. Unused bits read 0; counters are zero-extended.
- Register map:
  - 0x000 VERSION RO.
  - 0x004 GLOBAL RW: bit0 EN; bit1 CLR, write-1 self-clearing, reads 0.
  - Channel c at base 0x100+c*0x10:
    - +0x0 CTRL W: bit0 FIRE (W1); [15:8] REPEAT (0 is treated as 1); [31:16] GAP in cycles. Reads return the last written REPEAT/GAP, with bit0 reading 0.
    - +0x4 COUNT RO: acked interrupts.
    - +0x8 LAT RO: last ack latency.
    - +0xC STATUS RO: [1:0] state (0=IDLE, 1=ASSERT, 2=GAP); [15:8] remaining repeats; bit16 sticky TIMEOUT flag, cleared by CLR.
- PSLVERR=1 for any of:
  - unmapped address (including channel index >= NUM_CH);
  - write to a RO register;
  - FIRE written while the channel is not IDLE. The write is then ignored entirely.
- Channel FSM:
  - IDLE: irq=0. FIRE with EN=1 loads rem=REPEAT (min 1), next state ASSERT. FIRE with EN=0 is ignored, no error.
  - ASSERT: irq=1. lat_cnt=1 on the first cycle and increments (saturating) each cycle ack=0. When ack=1 is sampled:
    - COUNT+1 (saturating at 2^CNT_W-1);
    - LAT<=lat_cnt;
    - rem-1;
    - next state IDLE if rem reaches 0, else GAP.
  - GAP: irq=0 for max(GAP,1) cycles, then ASSERT.
- irq is registered and changes on the cycle after the FSM state transition edge. irq always has at least one low cycle between repeats.
- ack outside ASSERT is ignored.
- Simultaneous acks on multiple channels are processed independently in the same cycle.
- Clearing EN (write GLOBAL bit0=0) forces every channel to IDLE and drops irq on the next edge. COUNT and LAT are kept.
- CLR zeroes all COUNT, LAT and TIMEOUT flags. If CLR and an ack increment occur in the same cycle, CLR wins (result 0). CLR does not change FSM state.

Optional Feature:
- ACK_TIMEOUT_EN defined:
  - A channel in ASSERT for TIMEOUT cycles without ack drops irq, sets the sticky TIMEOUT flag, and does not increment COUNT or update LAT.
  - The timeout consumes one repeat and follows the same next-state rules as an ack.
  - An ack sampled in the same cycle as the timeout wins.
- ACK_TIMEOUT_EN undefined: irq is held indefinitely until ack; STATUS bit16 reads 0.

Test Plan:
- Reset, then read 0x000 -> PRDATA=32'h0002_0000, PSLVERR=0. Read 0x010 -> PSLVERR=1.
- GLOBAL=1; write ch0 CTRL=0x0000_0001; assert ack[0] on the 5th irq-high edge -> irq[0] falls on the following edge, COUNT0=1, LAT0=5, STATUS0 state=IDLE.
- ch1 CTRL=0x0004_0301 (REPEAT=3, GAP=4), ack each assertion after 2 cycles -> three irq pulses, each low gap 4 cycles, COUNT1=3, then IDLE.
- Write FIRE to ch1 while it is in ASSERT -> PSLVERR=1, rem unchanged. Write 0x108 -> PSLVERR=1.
- Acks on ch0 and ch2 in the same cycle -> both COUNTs increment. Write GLOBAL CLR in the same cycle as an ack -> COUNT=0.
- Drop PRESETn mid-GAP -> irq=0 and all registers 0 immediately. With ACK_TIMEOUT_EN and TIMEOUT=8, no ack -> irq drops after 8 cycles, STATUS bit16=1, COUNT unchanged.
